// File: rtl/uart_rx_if.sv
// UART receive data interface: received word, status flags and consumer ack.
// master = receiver (drives data/status), slave = consumer (drives Data_Ack).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Data_Out;
  logic                 Data_Valid;
  logic                 Data_Ack;
  logic                 Framing_Error;
  logic                 Overrun;

  modport master (
    output Data_Out,
    output Data_Valid,
    output Framing_Error,
    output Overrun,
    input  Data_Ack
  );

  modport slave (
    input  Data_Out,
    input  Data_Valid,
    input  Framing_Error,
    input  Overrun,
    output Data_Ack
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: Clock/Reset_n/Sample_Tick/RX in, Busy out,
// word + Data_Valid/Framing_Error/Overrun via rx_if (master), Data_Ack in.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Sample_Tick,
  input  logic RX,
  output logic Busy,
  uart_rx_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Detection tick counts as tick 0 of the start bit, so the
  // start-bit check lands on tick OVERSAMPLE/2-1 (mid-bit).
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 2);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 fe_q, fe_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 ovr_q, ovr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX};
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    fe_d    = 1'b0;
    if (Sample_Tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = S_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d = '0;
            if (rx_s) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // A frame completing while the previous word is still pending is an
  // overrun, unless the consumer acks in that very cycle.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    ovr_d  = ovr_q;
    if (done_q) begin
      dout_d = shift_q;
      dv_d   = 1'b1;
      if (dv_q && !rx_if.Data_Ack) begin
        ovr_d = 1'b1;
      end
    end else if (dv_q && rx_if.Data_Ack) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Busy                = (state_q != S_IDLE);
  assign rx_if.Data_Out      = dout_q;
  assign rx_if.Data_Valid    = dv_q;
  assign rx_if.Framing_Error = fe_q;
  assign rx_if.Overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus directed
// sequences for glitch, framing error, overrun, ack race and reset.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic Sample_Tick = 1'b0;
  logic RX = 1'b1;
  logic Busy;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Sample_Tick(Sample_Tick),
    .RX         (RX),
    .Busy       (Busy),
    .rx_if      (bus)
  );

  always #5 Clock = ~Clock;

  int   n_run = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   tick_div = 1;
  int   tick_cnt = 0;
  int   ack_at = -1;
  int   dv_rise = -1;
  int   fe_cnt = 0;
  int   last_fall = 0;
  logic dv_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         div;
    logic [7:0] e_dout;
    logic       e_dv;
    int         e_fe;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cycle);
    end
  endtask

  // One clock: observe at negedge, then drive tick/ack for next posedge.
  task automatic cyc();
    @(negedge Clock);
    cycle++;
    if (bus.Data_Valid && !dv_prev && dv_rise < 0) dv_rise = cycle;
    dv_prev = bus.Data_Valid;
    if (bus.Framing_Error) fe_cnt++;
    bus.Data_Ack = (cycle == ack_at);
    if (tick_div <= 1) begin
      Sample_Tick = 1'b1;
    end else begin
      Sample_Tick = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1) % tick_div;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      cyc();
      if (Sample_Tick) k++;
    end
  endtask

  task automatic clear_mon();
    dv_rise = -1;
    fe_cnt = 0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    RX = 1'b1;
    idle(3);
    Reset_n = 1'b1;
    idle(2);
  endtask

  // Stop bit level is left on the line when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    last_fall = cycle;
    RX = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      RX = d[i];
      wait_ticks(OS);
    end
    RX = stop;
    wait_ticks(OS);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b1, 0};
    tbl[1] = '{8'h3C, 1'b0, 1, 8'h00, 1'b0, 1};
    tbl[2] = '{8'h00, 1'b1, 1, 8'h00, 1'b1, 0};
    tbl[3] = '{8'h0F, 1'b1, 2, 8'h0F, 1'b1, 0};
    tbl[4] = '{8'h80, 1'b1, 4, 8'h80, 1'b1, 0};
    tbl[5] = '{8'hC3, 1'b0, 4, 8'h00, 1'b0, 1};

    bus.Data_Ack = 1'b0;
    Reset_n = 1'b0;
    idle(2);
    chk("rst_dout", 32'(bus.Data_Out), 0);
    chk("rst_dv", 32'(bus.Data_Valid), 0);
    chk("rst_fe", 32'(bus.Framing_Error), 0);
    chk("rst_ovr", 32'(bus.Overrun), 0);
    chk("rst_busy", 32'(Busy), 0);
    Reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      tick_div = tbl[i].div;
      do_reset();
      clear_mon();
      send_frame(tbl[i].data, tbl[i].stop);
      RX = 1'b1;
      idle(40 * tbl[i].div);
      chk($sformatf("v%0d_dout", i), 32'(bus.Data_Out), 32'(tbl[i].e_dout));
      chk($sformatf("v%0d_dv", i), 32'(bus.Data_Valid), 32'(tbl[i].e_dv));
      chk($sformatf("v%0d_fe", i), 32'(fe_cnt), 32'(tbl[i].e_fe));
      chk($sformatf("v%0d_ovr", i), 32'(bus.Overrun), 0);
      chk($sformatf("v%0d_busy", i), 32'(Busy), 0);
    end

    // Latency, one tick per clock: 2 sync + 152 ticks + 1 load clock.
    tick_div = 1;
    do_reset();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("lat1", 32'(dv_rise - last_fall), 155);
    chk("lat1_dout", 32'(bus.Data_Out), 32'h A5);
    chk("lat1_fe", 32'(fe_cnt), 0);

    // Start-bit glitch of 4 ticks is rejected.
    do_reset();
    clear_mon();
    RX = 1'b0;
    wait_ticks(4);
    chk("glitch_busy_hi", 32'(Busy), 1);
    RX = 1'b1;
    idle(20);
    chk("glitch_busy_lo", 32'(Busy), 0);
    chk("glitch_dv", 32'(bus.Data_Valid), 0);

    // Bad stop bit with the line held low afterwards.
    do_reset();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    idle(40);
    chk("brk_busy", 32'(Busy), 1);
    chk("brk_fe_pulse", 32'(fe_cnt), 1);
    chk("brk_dv", 32'(bus.Data_Valid), 0);
    RX = 1'b1;
    idle(5);
    chk("brk_release", 32'(Busy), 0);
    chk("brk_fe_once", 32'(fe_cnt), 1);

    // Back-to-back frames without ack -> overrun.
    do_reset();
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    chk("ovr_dout", 32'(bus.Data_Out), 32'h22);
    chk("ovr_dv", 32'(bus.Data_Valid), 1);
    chk("ovr_set", 32'(bus.Overrun), 1);
    ack_at = cycle + 1;
    idle(3);
    chk("ovr_ack_dv", 32'(bus.Data_Valid), 0);
    chk("ovr_sticky", 32'(bus.Overrun), 1);

    // Ack in the same clock the next word loads: no overrun.
    do_reset();
    clear_mon();
    send_frame(8'h11, 1'b1);
    idle(20);
    chk("race_dv0", 32'(bus.Data_Valid), 1);
    ack_at = cycle + 154;
    send_frame(8'h22, 1'b1);
    idle(20);
    chk("race_dout", 32'(bus.Data_Out), 32'h22);
    chk("race_dv", 32'(bus.Data_Valid), 1);
    chk("race_ovr", 32'(bus.Overrun), 0);

    // Reset in the middle of the data bits of 0x55.
    do_reset();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("mid_pre_dv", 32'(bus.Data_Valid), 1);
    RX = 1'b0;
    wait_ticks(OS);
    RX = 1'b1;
    wait_ticks(OS);
    RX = 1'b0;
    wait_ticks(OS / 2);
    Reset_n = 1'b0;
    #1;
    chk("mid_dout", 32'(bus.Data_Out), 0);
    chk("mid_dv", 32'(bus.Data_Valid), 0);
    chk("mid_busy", 32'(Busy), 0);
    chk("mid_fe", 32'(bus.Framing_Error), 0);
    chk("mid_ovr", 32'(bus.Overrun), 0);
    RX = 1'b1;
    idle(2);
    Reset_n = 1'b1;
    idle(30);
    clear_mon();
    send_frame(8'h0F, 1'b1);
    idle(20);
    chk("mid_next_dout", 32'(bus.Data_Out), 32'h0F);
    chk("mid_next_dv", 32'(bus.Data_Valid), 1);
    chk("mid_next_fe", 32'(fe_cnt), 0);

    // One tick every 4th clock: 2 + [1..4] + 151*4 + 1 clocks.
    tick_div = 4;
    do_reset();
    clear_mon();
    send_frame(8'hFF, 1'b1);
    idle(40);
    lat = dv_rise - last_fall;
    chk("lat4_dout", 32'(bus.Data_Out), 32'hFF);
    chk("lat4_dv", 32'(bus.Data_Valid), 1);
    if (lat < 608 || lat > 611) begin
      n_run++;
      n_fail++;
      $display("FAIL lat4: got %0d expected 608..611", lat);
    end else begin
      n_run++;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, Sample_Tick pulses per bit period (even, >=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-003 SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Sample_Tick  input  1  one-Clock-wide enable at OVERSAMPLE x baud, from the baud generator.
REQ-006 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port Data_Ack  input  1  consumer acknowledge; clears Data_Valid.
REQ-008 SHALL have port Data_Out  output  DATA_BITS  last good received word, LSB = first bit on the line.
REQ-009 SHALL have port Data_Valid  output  1  level; high while Data_Out holds an unacknowledged word.
REQ-010 SHALL have port Framing_Error  output  1  one-Clock pulse when a stop bit samples low.
REQ-011 SHALL have port Overrun  output  1  sticky; set when a new word completes while Data_Valid is high.
REQ-012 SHALL have port Busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL pass RX through a 2-flop synchronizer, reset value 1; all line decisions use the synchronized value (rx_s).
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK_WAIT; a tick counter (0..OVERSAMPLE-1) and a bit counter (0..DATA_BITS-1) advance only on Sample_Tick.
REQ-015 IDLE: on a Sample_Tick with rx_s=0 -> START, tick counter cleared.
REQ-016 START: on the Sample_Tick where the tick counter reaches OVERSAMPLE/2-1, rx_s=0 -> DATA (tick and bit counters cleared); rx_s=1 -> IDLE (glitch rejected, no output change).
REQ-017 DATA: every OVERSAMPLE ticks, shift rx_s into the shift register MSB-ward (LSB first on line); after DATA_BITS samples -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample rx_s; 1 -> valid frame, IDLE; 0 -> Framing_Error pulse, Data_Out/Data_Valid unchanged, BREAK_WAIT.
REQ-019 BREAK_WAIT: stay until a Sample_Tick with rx_s=1, then IDLE.
REQ-020 Valid frame: on the Clock after the stop-sample tick, load Data_Out, set Data_Valid; if Data_Valid was already high and not acknowledged that cycle, set Overrun and overwrite Data_Out.
REQ-021 Data_Ack while Data_Valid=1 SHALL clear Data_Valid next Clock; Data_Ack while Data_Valid=0 ignored.
REQ-022 Simultaneous Data_Ack and new valid frame: new word loaded, Data_Valid stays high, Overrun not set.
REQ-023 Overrun SHALL clear only on reset.
REQ-024 Sample_Tick low SHALL freeze all counters and the FSM (except synchronizer and Data_Ack handling).
REQ-025 Latency: RX falling edge to Data_Valid high = 2 Clock (sync) + (DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2 ticks + 1 Clock.

Reset
REQ-026 Reset_n low SHALL asynchronously force IDLE, counters 0, shift register 0, Data_Out=0, Data_Valid=0, Framing_Error=0, Overrun=0, Busy=0, synchronizer=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the receiver waits for a fresh start bit (a line held low is treated as a start bit).

Verification
REQ-028 Sample_Tick every Clock, defaults, frame 0xA5 (start,1,0,1,0,0,1,0,1,stop) -> Data_Out=0xA5, Data_Valid=1 at 2+152+1 Clocks after RX fall, Framing_Error=0.
REQ-029 RX low for 4 ticks then high -> state returns to IDLE, Busy drops, Data_Valid stays 0.
REQ-030 Frame 0x3C with stop bit driven 0 -> Framing_Error pulse exactly one Clock, Data_Valid 0, Busy stays high until RX returns high.
REQ-031 Two back-to-back frames 0x11, 0x22 with no Data_Ack -> Data_Out=0x22, Data_Valid=1, Overrun=1; Data_Ack -> Data_Valid=0, Overrun still 1.
REQ-032 Reset_n pulsed low during DATA of frame 0x55 -> all outputs 0 immediately; next clean frame 0x0F received correctly.
REQ-033 Sample_Tick every 4th Clock, frame 0xFF -> Data_Out=0xFF, Data_Valid=1, latency scaled 4x in ticks.
